awg_cmd_ctrl: RTL and testbench
===============================

# awg_cmd_ctrl

Byte-stream command controller for the AWG datapath. It parses ASCII commands from the UART receiver (letter, decimal digits, line terminator), range-checks them, and holds the waveform, frequency, amplitude and phase configuration that drives the DDS core. Every command produces a one-byte acknowledge to the UART transmitter. Parameter changes can be applied atomically at a DDS phase wrap so the output never glitches mid-period.

## Interface
Parameters:
- `DEF_STATE`, 5'd3: reset waveform select.
- `DEF_FREQ`, 12'd1: reset frequency word.
- `DEF_AMP`, 8'd50: reset amplitude.
- `DEF_PHASE`, 8'd50: reset phase offset.
- `MAX_DIGITS`, 5: maximum decimal digits per command.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: one-cycle strobe marking `rx_data` valid.
- `tx_data`  out  8: acknowledge byte.
- `tx_valid`  out  1: `tx_data` valid. Held until accepted.
- `tx_ready`  in  1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `phase_wrap`  in  1: DDS accumulator wrap pulse.
- `state`  out  5: waveform select.
- `state_freq`  out  12: frequency word.
- `state_amp`  out  8: amplitude.
- `state_phase`  out  8: phase offset.
- `cfg_update`  out  1: one-cycle pulse, asserted the cycle after the outputs change.

## Operation
- Command letters: 'W' (0x57) sets `state`, max 31. 'F' (0x46) sets `state_freq`, max 4095. 'A' (0x41) sets `state_amp`, max 255. 'P' (0x50) sets `state_phase`, max 255.
- Terminators are CR (0x0D) and LF (0x0A).
- FSM states: IDLE, DIGITS, COMMIT, ACK.
- IDLE:
  - A command letter latches the target field, clears the accumulator and digit count, and moves to DIGITS.
  - Any other byte, including a terminator, is ignored silently.
- DIGITS:
  - A byte '0'–'9' updates `acc <= acc*10 + (byte-0x30)`. The accumulator is 17 bits wide; ×10 is computed as shift-add.
  - A terminator moves to COMMIT.
  - An error is flagged and the FSM moves to ACK on any of: a non-digit, non-terminator byte; digit number MAX_DIGITS+1; a terminator with zero digits. The offending byte is discarded.
- COMMIT:
  - If `acc` ≤ the field maximum, write the pending (shadow) register for that field and set its pending flag. Result is OK.
  - Otherwise the result is an error and nothing is written.
  - Always moves to ACK.
- ACK:
  - `tx_data` is 'K' (0x4B) for OK or 'E' (0x45) for an error. `tx_valid` is held high.
  - On `tx_ready`, return to IDLE.
  - `rx_valid` bytes arriving in ACK or COMMIT are dropped.
- Apply: pending shadow values transfer to the outputs (see Configuration). All pending fields transfer together, and the pending flags clear.
- Multiple commits to the same field before an apply: the last value wins.
- Reset, including mid-command: FSM to IDLE, partial command discarded, `tx_valid` = 0, `cfg_update` = 0, pending flags cleared, shadows and outputs = DEF_* parameters.

## Timing
- Bytes are consumed on the `rx_valid` cycle in IDLE and DIGITS. Back-to-back `rx_valid` is supported.
- Terminator accepted in cycle T: COMMIT in T+1, ACK in T+2 with `tx_valid` = 1 from T+2.
- Error byte accepted in cycle T: ACK in T+1.
- With `tx_ready` held high, `tx_valid` lasts exactly one cycle and the FSM is in IDLE the next cycle.
- `cfg_update` is high exactly one cycle after an apply edge, and only if at least one field was pending.
- If COMMIT and `phase_wrap` fall in the same cycle, the wrap applies only the previously pending values. The new value applies at the next wrap.

## Configuration
- `AWG_WRAP_SYNC_EN` defined:
  - Apply occurs on the clock edge where `phase_wrap` = 1 and any field is pending.
  - Outputs change at that edge; `cfg_update` pulses the following cycle.
- `AWG_WRAP_SYNC_EN` undefined:
  - `phase_wrap` is ignored.
  - Apply occurs on the edge ending COMMIT (OK result): outputs are valid from T+2 and `cfg_update` pulses in T+2.

## Structure
- Package `awg_pkg`:
  - ASCII constants (letters, digits base, CR, LF, 'K', 'E').
  - FSM state enum.
  - Field selector enum (W/F/A/P).
  - Field widths and maxima (31, 4095, 255, 255).
- Sub-module `dec_accum`: digit accumulator with clear/add-digit inputs, 17-bit value output, digit count, and overflow-count flag.

## Test plan
- "F524\r", `tx_ready` = 1, sync undefined → 'K' at T+2; `state_freq` = 524 at T+2; `cfg_update` pulses once.
- "A300\n" → 'E'; `state_amp` stays 50; no `cfg_update`.
- "P1x\n" → 'E' on the 'x' byte; the following "\n" is ignored; then "P90\n" → 'K' and `state_phase` = 90.
- Sync defined: "F1000\r" then "W2\r", `phase_wrap` first pulsed after both ACKs → `state_freq` = 1000 and `state` = 2 change on the same edge; one `cfg_update` pulse.
- `tx_ready` = 0 for 10 cycles during ACK, with bytes sent meanwhile → 'K' held stable; bytes dropped; IDLE after `tx_ready`.
- `rst` asserted after "F12" → outputs are defaults the next cycle; a subsequent "3\r" is ignored (no ack).

Source files
------------

// File: rtl/awg_pkg.sv
// Shared constants and types for the AWG command controller.
// Holds the ASCII byte codes, FSM and field selector enums, and field widths and maxima.
// Also holds the small byte-classification helpers used by the parser.
package awg_pkg;

    localparam logic [7:0] ASC_W  = 8'h57;
    localparam logic [7:0] ASC_F  = 8'h46;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_P  = 8'h50;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_K  = 8'h4B;
    localparam logic [7:0] ASC_E  = 8'h45;

    // Five decimal digits (99999) fit in 17 bits.
    localparam int ACC_W = 17;

    localparam int W_WIDTH = 5;
    localparam int F_WIDTH = 12;
    localparam int A_WIDTH = 8;
    localparam int P_WIDTH = 8;

    localparam logic [ACC_W-1:0] W_MAX = 17'd31;
    localparam logic [ACC_W-1:0] F_MAX = 17'd4095;
    localparam logic [ACC_W-1:0] A_MAX = 17'd255;
    localparam logic [ACC_W-1:0] P_MAX = 17'd255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIGITS = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ACK    = 2'd3
    } fsm_t;

    typedef enum logic [1:0] {
        FLD_W = 2'd0,
        FLD_F = 2'd1,
        FLD_A = 2'd2,
        FLD_P = 2'd3
    } field_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASC_CR) || (b == ASC_LF);
    endfunction

    function automatic logic [ACC_W-1:0] field_max(input field_t f);
        logic [ACC_W-1:0] m;
        case (f)
            FLD_W:   m = W_MAX;
            FLD_F:   m = F_MAX;
            FLD_A:   m = A_MAX;
            default: m = P_MAX;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: value <= value*10 + digit, with a digit counter.
// Latency: one cycle from i_add to the updated o_value/o_count.
// No backpressure; o_full flags that another digit would exceed MAX_DIGITS.
module dec_accum
    import awg_pkg::*;
#(
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [3:0]       i_digit,
    output logic [ACC_W-1:0] o_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [ACC_W-1:0] r_value;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] w_times10;
    logic             w_full;

    // x*10 as (x<<3) + (x<<1); the digit cap keeps the result inside ACC_W bits.
    always_comb begin
        w_times10 = {r_value[ACC_W-4:0], 3'b000} + {r_value[ACC_W-2:0], 1'b0};
        w_full    = (r_count == CNT_W'(MAX_DIGITS));
    end

    // Clear wins over add; an add while full is refused so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_add && !w_full) begin
            r_value <= w_times10 + {{(ACC_W-4){1'b0}}, i_digit};
            r_count <= r_count + 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/awg_cmd_ctrl.sv
// ASCII command parser holding the DDS waveform/frequency/amplitude/phase configuration; optional macro AWG_WRAP_SYNC_EN.
// Latency: terminator in cycle T -> ack byte from T+2; error byte in T -> ack from T+1; unsynced apply at T+2.
// Backpressure: tx_valid is held until tx_ready; rx bytes arriving during COMMIT/ACK are dropped.
module awg_cmd_ctrl
    import awg_pkg::*;
#(
    parameter logic [4:0]  DEF_STATE  = 5'd3,
    parameter logic [11:0] DEF_FREQ   = 12'd1,
    parameter logic [7:0]  DEF_AMP    = 8'd50,
    parameter logic [7:0]  DEF_PHASE  = 8'd50,
    parameter int          MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        phase_wrap,
    output logic [4:0]  state,
    output logic [11:0] state_freq,
    output logic [7:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        cfg_update
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    fsm_t   r_fsm;
    fsm_t   w_fsm_nxt;
    field_t r_field;
    field_t w_letter_fld;
    logic   w_is_letter;
    logic   w_is_digit;
    logic   w_is_term;
    logic   r_ok;

    logic [ACC_W-1:0] w_acc;
    logic [CNT_W-1:0] w_acc_cnt;
    logic             w_acc_full;
    logic             w_acc_clr;
    logic             w_acc_add;
    logic             w_dig_err;
    logic             w_commit;
    logic             w_in_range;
    logic             w_commit_ok;
    logic             w_apply;

    logic [W_WIDTH-1:0] r_sh_w, r_out_w, w_sh_w_nxt, w_src_w;
    logic [F_WIDTH-1:0] r_sh_f, r_out_f, w_sh_f_nxt, w_src_f;
    logic [A_WIDTH-1:0] r_sh_a, r_out_a, w_sh_a_nxt, w_src_a;
    logic [P_WIDTH-1:0] r_sh_p, r_out_p, w_sh_p_nxt, w_src_p;
    logic               r_cfg_update;

    dec_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_dec_accum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_acc_clr),
        .i_add   (w_acc_add),
        .i_digit (rx_data[3:0]),
        .o_value (w_acc),
        .o_count (w_acc_cnt),
        .o_full  (w_acc_full)
    );

    // Classify the incoming byte.
    always_comb begin
        w_is_digit   = is_digit(rx_data);
        w_is_term    = is_term(rx_data);
        w_is_letter  = 1'b1;
        w_letter_fld = FLD_W;
        case (rx_data)
            ASC_W:   w_letter_fld = FLD_W;
            ASC_F:   w_letter_fld = FLD_F;
            ASC_A:   w_letter_fld = FLD_A;
            ASC_P:   w_letter_fld = FLD_P;
            default: w_is_letter  = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= ST_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE: begin
                if (rx_valid && w_is_letter) w_fsm_nxt = ST_DIGITS;
            end
            ST_DIGITS: begin
                if (rx_valid) begin
                    if (w_is_term)
                        w_fsm_nxt = (w_acc_cnt == '0) ? ST_ACK : ST_COMMIT;
                    else if (!w_is_digit || w_acc_full)
                        w_fsm_nxt = ST_ACK;
                end
            end
            ST_COMMIT: w_fsm_nxt = ST_ACK;
            ST_ACK: begin
                if (tx_ready) w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: accumulator strobes, error/commit decode and the ack byte.
    always_comb begin
        w_acc_clr = (r_fsm == ST_IDLE) && rx_valid && w_is_letter;
        w_acc_add = (r_fsm == ST_DIGITS) && rx_valid && w_is_digit && !w_acc_full;
        w_dig_err = (r_fsm == ST_DIGITS) && rx_valid &&
                    ((w_is_term && (w_acc_cnt == '0)) ||
                     (!w_is_term && !w_is_digit) ||
                     (w_is_digit && w_acc_full));
        w_commit  = (r_fsm == ST_COMMIT);
        tx_valid  = (r_fsm == ST_ACK);
        tx_data   = r_ok ? ASC_K : ASC_E;
    end

    // Range check against the latched field, and the next shadow values.
    always_comb begin
        w_in_range  = (w_acc <= field_max(r_field));
        w_commit_ok = w_commit && w_in_range;
        w_sh_w_nxt  = r_sh_w;
        w_sh_f_nxt  = r_sh_f;
        w_sh_a_nxt  = r_sh_a;
        w_sh_p_nxt  = r_sh_p;
        if (w_commit_ok) begin
            case (r_field)
                FLD_W:   w_sh_w_nxt = w_acc[W_WIDTH-1:0];
                FLD_F:   w_sh_f_nxt = w_acc[F_WIDTH-1:0];
                FLD_A:   w_sh_a_nxt = w_acc[A_WIDTH-1:0];
                default: w_sh_p_nxt = w_acc[P_WIDTH-1:0];
            endcase
        end
    end

    // Latch the target field on the command letter and the result for the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_field <= FLD_W;
            r_ok    <= 1'b0;
        end else begin
            if (w_acc_clr) r_field <= w_letter_fld;
            if (w_dig_err)     r_ok <= 1'b0;
            else if (w_commit) r_ok <= w_in_range;
        end
    end

    // Shadow registers: last committed value per field wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_w <= DEF_STATE;
            r_sh_f <= DEF_FREQ;
            r_sh_a <= DEF_AMP;
            r_sh_p <= DEF_PHASE;
        end else begin
            r_sh_w <= w_sh_w_nxt;
            r_sh_f <= w_sh_f_nxt;
            r_sh_a <= w_sh_a_nxt;
            r_sh_p <= w_sh_p_nxt;
        end
    end

`ifdef AWG_WRAP_SYNC_EN
    logic [3:0] r_pend;
    logic [3:0] w_pend_set;

    // A wrap moves only values already sitting in the shadows; a commit on the
    // same edge stays pending for the next wrap.
    always_comb begin
        w_pend_set = '0;
        if (w_commit_ok) w_pend_set[r_field] = 1'b1;
        w_apply = phase_wrap && (|r_pend);
        w_src_w = r_sh_w;
        w_src_f = r_sh_f;
        w_src_a = r_sh_a;
        w_src_p = r_sh_p;
    end

    // Pending flags: cleared by an apply, set by a successful commit.
    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else     r_pend <= (w_apply ? 4'b0000 : r_pend) | w_pend_set;
    end
`else
    // Without wrap sync the committed value goes straight to the outputs.
    always_comb begin
        w_apply = w_commit_ok;
        w_src_w = w_sh_w_nxt;
        w_src_f = w_sh_f_nxt;
        w_src_a = w_sh_a_nxt;
        w_src_p = w_sh_p_nxt;
    end
`endif

    // Output configuration registers and the update pulse that follows an apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_w      <= DEF_STATE;
            r_out_f      <= DEF_FREQ;
            r_out_a      <= DEF_AMP;
            r_out_p      <= DEF_PHASE;
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= w_apply;
            if (w_apply) begin
                r_out_w <= w_src_w;
                r_out_f <= w_src_f;
                r_out_a <= w_src_a;
                r_out_p <= w_src_p;
            end
        end
    end

    assign state       = r_out_w;
    assign state_freq  = r_out_f;
    assign state_amp   = r_out_a;
    assign state_phase = r_out_p;
    assign cfg_update  = r_cfg_update;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Directed bench for awg_cmd_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Covers both the default build and the AWG_WRAP_SYNC_EN build.
module tb_awg_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        phase_wrap;
    logic [4:0]  state;
    logic [11:0] state_freq;
    logic [7:0]  state_amp;
    logic [7:0]  state_phase;
    logic        cfg_update;

    localparam logic [7:0] K_BYTE = 8'h4B;
    localparam logic [7:0] E_BYTE = 8'h45;

    int n_checks = 0;
    int n_errors = 0;
    int cfg_cnt  = 0;
    int c0;

    awg_cmd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .phase_wrap  (phase_wrap),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .cfg_update  (cfg_update)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_update) cfg_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Stream a string back-to-back; returns on the falling edge after the last byte.
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        int n;
        n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(tx_valid), 32'd1);
    endtask

    task automatic wait_ack(input string tag, input logic [7:0] exp);
        wait_tx(tag);
        chk({tag, "_ack"}, 32'(tx_data), 32'(exp));
        @(negedge clk);
    endtask

    task automatic expect_quiet(input string tag, input int ncyc);
        int seen;
        seen = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    // With wrap sync, pending values only reach the outputs on a wrap pulse.
    task automatic apply_cfg();
`ifdef AWG_WRAP_SYNC_EN
        @(negedge clk);
        phase_wrap = 1'b1;
        @(negedge clk);
        phase_wrap = 1'b0;
        @(negedge clk);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_bad;
        string junk;

        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b1;
        phase_wrap = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_txv",   32'(tx_valid),    32'd0);
        chk("rst_cfg",   32'(cfg_update),  32'd0);
        chk("rst_state", 32'(state),       32'd3);
        chk("rst_freq",  32'(state_freq),  32'd1);
        chk("rst_amp",   32'(state_amp),   32'd50);
        chk("rst_phase", 32'(state_phase), 32'd50);
        rst = 1'b0;

        // F524<CR>: exact ack and apply timing
        c0 = cfg_cnt;
        send_str("F524\015");
`ifndef AWG_WRAP_SYNC_EN
        chk("f524_t1_txv", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("f524_t2_txv",  32'(tx_valid),   32'd1);
        chk("f524_t2_dat",  32'(tx_data),    32'(K_BYTE));
        chk("f524_t2_freq", 32'(state_freq), 32'd524);
        chk("f524_t2_cfg",  32'(cfg_update), 32'd1);
        @(negedge clk);
        chk("f524_t3_txv", 32'(tx_valid),   32'd0);
        chk("f524_t3_cfg", 32'(cfg_update), 32'd0);
        chk("f524_cfg_cnt", 32'(cfg_cnt - c0), 32'd1);
`else
        wait_ack("f524", K_BYTE);
        chk("f524_pre_wrap_freq", 32'(state_freq), 32'd1);
        apply_cfg();
        chk("f524_freq", 32'(state_freq), 32'd524);
        chk("f524_cfg_cnt", 32'(cfg_cnt - c0), 32'd1);
`endif

        // A300<LF>: out of range
        c0 = cfg_cnt;
        send_str("A300\012");
        wait_ack("a300", E_BYTE);
        apply_cfg();
        chk("a300_amp", 32'(state_amp), 32'd50);
        chk("a300_cfg_cnt", 32'(cfg_cnt - c0), 32'd0);

        // P1x: error on the 'x', ack in the next cycle; trailing LF ignored
        send_str("P1x");
        chk("p1x_txv", 32'(tx_valid), 32'd1);
        chk("p1x_dat", 32'(tx_data),  32'(E_BYTE));
        send_str("\012");
        expect_quiet("p1x_lf_quiet", 5);
        send_str("P90\012");
        wait_ack("p90", K_BYTE);
        apply_cfg();
        chk("p90_phase", 32'(state_phase), 32'd90);

        // Sixth digit is an error right away
        send_str("W123456");
        chk("w6dig_txv", 32'(tx_valid), 32'd1);
        chk("w6dig_dat", 32'(tx_data),  32'(E_BYTE));
        send_str("\015");
        expect_quiet("w6dig_cr_quiet", 5);
        chk("w6dig_state", 32'(state), 32'd3);

        // Field maxima and range boundaries
        send_str("W00031\015");
        wait_ack("w31", K_BYTE);
        apply_cfg();
        chk("w31_state", 32'(state), 32'd31);
        send_str("W32\015");
        wait_ack("w32", E_BYTE);
        apply_cfg();
        chk("w32_state", 32'(state), 32'd31);
        send_str("F4095\015");
        wait_ack("f4095", K_BYTE);
        apply_cfg();
        chk("f4095_freq", 32'(state_freq), 32'd4095);
        send_str("F12345\015");
        wait_ack("f12345", E_BYTE);
        apply_cfg();
        chk("f12345_freq", 32'(state_freq), 32'd4095);
        send_str("A\015");
        wait_ack("a_empty", E_BYTE);

        // Ack held while tx_ready is low; bytes sent meanwhile are dropped
        tx_ready = 1'b0;
        send_str("A7\015");
        wait_tx("hold");
        hold_bad = 0;
        junk = "F9\015F8\015W1\015x";
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data != K_BYTE) hold_bad++;
            rx_data  = junk[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        if (!tx_valid || tx_data != K_BYTE) hold_bad++;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk("hold_stable", 32'(hold_bad), 32'd0);
        @(negedge clk);
        chk("hold_release_txv", 32'(tx_valid), 32'd0);
        apply_cfg();
        chk("hold_amp",   32'(state_amp),  32'd7);
        chk("hold_freq",  32'(state_freq), 32'd4095);
        chk("hold_state", 32'(state),      32'd31);
        send_str("A8\015");
        wait_ack("a8", K_BYTE);
        apply_cfg();
        chk("a8_amp", 32'(state_amp), 32'd8);

`ifdef AWG_WRAP_SYNC_EN
        // Two commits, one wrap: both fields change on the same edge
        c0 = cfg_cnt;
        send_str("F1000\015");
        wait_ack("f1000", K_BYTE);
        send_str("W2\015");
        wait_ack("w2", K_BYTE);
        chk("sync_pre_freq",  32'(state_freq), 32'd4095);
        chk("sync_pre_state", 32'(state),      32'd31);
        @(negedge clk);
        phase_wrap = 1'b1;
        @(negedge clk);
        phase_wrap = 1'b0;
        chk("sync_freq",  32'(state_freq), 32'd1000);
        chk("sync_state", 32'(state),      32'd2);
        chk("sync_cfg",   32'(cfg_update), 32'd1);
        @(negedge clk);
        chk("sync_cfg_off", 32'(cfg_update), 32'd0);
        phase_wrap = 1'b1;
        @(negedge clk);
        phase_wrap = 1'b0;
        @(negedge clk);
        chk("sync_cfg_cnt", 32'(cfg_cnt - c0), 32'd1);
`else
        // phase_wrap has no effect without wrap sync
        c0 = cfg_cnt;
        @(negedge clk);
        phase_wrap = 1'b1;
        repeat (3) @(negedge clk);
        phase_wrap = 1'b0;
        @(negedge clk);
        chk("wrap_ignored_cfg", 32'(cfg_cnt - c0), 32'd0);
        send_str("F1000\015");
        wait_ack("f1000", K_BYTE);
        chk("f1000_freq", 32'(state_freq), 32'd1000);
`endif

        // Reset in the middle of a command
        send_str("F12");
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'(state),       32'd3);
        chk("mid_rst_freq",  32'(state_freq),  32'd1);
        chk("mid_rst_amp",   32'(state_amp),   32'd50);
        chk("mid_rst_phase", 32'(state_phase), 32'd50);
        chk("mid_rst_txv",   32'(tx_valid),    32'd0);
        rst = 1'b0;
        send_str("3\015");
        expect_quiet("mid_rst_no_ack", 6);
        chk("mid_rst_freq_after", 32'(state_freq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
